// File: rtl/clk_rate_arbiter.sv
// Programmable half-period clock divider with a two-requester round-robin
// rate-change arbiter; new counts are applied only at half-period boundaries.
module clk_rate_arbiter #(
    parameter int unsigned      WIDTH         = 32,
    parameter logic [WIDTH-1:0] DEFAULT_COUNT = WIDTH'(49_999_999)
) (
    input  logic             basys_clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] req_count0,
    input  logic [WIDTH-1:0] req_count1,
    output logic [1:0]       grant,
    output logic             busy,
    output logic [WIDTH-1:0] active_count,
    output logic             out_clk,
    output logic             tick
);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] active_q, active_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic             out_clk_q, out_clk_d;
    logic             tick_q, tick_d;
    logic             busy_q, busy_d;
    logic [1:0]       grant_q, grant_d;
    logic             ptr_q, ptr_d;
    logic             boundary_s;
    logic             win_s;

    assign boundary_s = (cnt_q == active_q);

    // Divider: count up to active_q, then wrap and toggle out_clk.
    always_comb begin
        cnt_d     = cnt_q + WIDTH'(1);
        out_clk_d = out_clk_q;
        tick_d    = 1'b0;
        if (boundary_s) begin
            cnt_d     = '0;
            out_clk_d = ~out_clk_q;
            tick_d    = 1'b1;
        end else begin
            tick_d    = 1'b0;
        end
    end

    // Round-robin choice: ptr_q names the requester favoured on a tie.
    always_comb begin
        win_s = 1'b0;
        if (req == 2'b11) begin
            win_s = ptr_q;
        end else begin
            win_s = req[1];
        end
    end

    // Arbiter FSM next-state: grant from IDLE, apply the pending count on a boundary.
    always_comb begin
        state_d   = state_q;
        grant_d   = 2'b00;
        busy_d    = busy_q;
        pending_d = pending_q;
        active_d  = active_q;
        ptr_d     = ptr_q;
        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    grant_d   = win_s ? 2'b10 : 2'b01;
                    pending_d = win_s ? req_count1 : req_count0;
                    ptr_d     = ~win_s;
                    busy_d    = 1'b1;
                    state_d   = PENDING;
                end else begin
                    busy_d    = 1'b0;
                end
            end
            PENDING: begin
                // Update lands on the wrap, so the next half-period uses the new count.
                if (boundary_s) begin
                    active_d = pending_q;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end else begin
                    busy_d   = 1'b1;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge basys_clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            active_q  <= DEFAULT_COUNT;
            pending_q <= '0;
            out_clk_q <= 1'b0;
            tick_q    <= 1'b0;
            busy_q    <= 1'b0;
            grant_q   <= 2'b00;
            ptr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            out_clk_q <= out_clk_d;
            tick_q    <= tick_d;
            busy_q    <= busy_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
        end
    end

    assign grant        = grant_q;
    assign busy         = busy_q;
    assign active_count = active_q;
    assign out_clk      = out_clk_q;
    assign tick         = tick_q;

endmodule

// File: tb/tb_clk_rate_arbiter.sv
// Scoreboard bench for clk_rate_arbiter: a half-period/request-level model
// predicts grant and toggle events; a monitor compares them as the DUT emits them.
module tb_clk_rate_arbiter;

    localparam int          W   = 32;
    localparam logic [31:0] DEF = 32'd3;

    logic          basys_clk = 1'b0;
    logic          reset     = 1'b1;
    logic [1:0]    req       = 2'b00;
    logic [W-1:0]  req_count0 = '0;
    logic [W-1:0]  req_count1 = '0;
    logic [1:0]    grant;
    logic          busy;
    logic [W-1:0]  active_count;
    logic          out_clk;
    logic          tick;

    clk_rate_arbiter #(.WIDTH(W), .DEFAULT_COUNT(DEF)) dut (
        .basys_clk    (basys_clk),
        .reset        (reset),
        .req          (req),
        .req_count0   (req_count0),
        .req_count1   (req_count1),
        .grant        (grant),
        .busy         (busy),
        .active_count (active_count),
        .out_clk      (out_clk),
        .tick         (tick)
    );

    always #5 basys_clk = ~basys_clk;

    typedef struct {
        int          cyc;
        logic [1:0]  gnt;
        logic        lvl;
        logic        bsy;
        logic [31:0] act;
    } ev_t;

    ev_t tick_exp[$];
    ev_t grant_exp[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit done     = 1'b0;
    bit prev_rst = 1'b0;

    // Driver-side requested inputs
    logic        rst_v = 1'b1;
    logic [1:0]  req_v = 2'b00;
    logic [31:0] c0_v  = 32'd0;
    logic [31:0] c1_v  = 32'd0;

    // Reference model: elapsed cycles in the current half-period, the live
    // half-period count, an optional waiting update and the last winner.
    longint m_elapsed = 0;
    longint m_active  = DEF;
    longint m_new     = 0;
    bit     m_wait    = 1'b0;
    bit     m_last    = 1'b1;
    bit     m_level   = 1'b0;

    always @(posedge basys_clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void fail(string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event not allowed here (cycle %0d)", name, cyc);
    endfunction

    // Predict what the rising edge numbered k does, given the driven inputs.
    function automatic void model_edge(int k);
        ev_t    e;
        bit     bnd;
        bit     win;
        longint half_len;
        if (rst_v) begin
            m_elapsed = 0; m_active = DEF; m_wait = 1'b0; m_last = 1'b1; m_level = 1'b0;
            return;
        end
        half_len = m_active + 1;
        bnd = (m_elapsed + 1 == half_len);
        if (m_wait && bnd) begin
            m_active = m_new;
            m_wait   = 1'b0;
        end else if (!m_wait && req_v != 2'b00) begin
            win    = (req_v == 2'b11) ? !m_last : req_v[1];
            m_last = win;
            m_new  = win ? c1_v : c0_v;
            m_wait = 1'b1;
            e.cyc = k; e.gnt = win ? 2'b10 : 2'b01; e.lvl = m_level; e.bsy = 1'b1; e.act = 32'(m_active);
            grant_exp.push_back(e);
            req_v[win] = 1'b0;
        end
        if (bnd) begin
            m_level = !m_level;
            e.cyc = k; e.gnt = 2'b00; e.lvl = m_level; e.bsy = m_wait; e.act = 32'(m_active);
            tick_exp.push_back(e);
            m_elapsed = 0;
        end else begin
            m_elapsed = m_elapsed + 1;
        end
    endfunction

    task automatic step();
        @(negedge basys_clk);
        if (prev_rst) begin
            check("reset_out_clk", 32'(out_clk), 32'd0);
            check("reset_tick", 32'(tick), 32'd0);
            check("reset_grant", 32'(grant), 32'd0);
            check("reset_busy", 32'(busy), 32'd0);
            check("reset_active_count", active_count, DEF);
        end
        reset      = rst_v;
        req        = req_v;
        req_count0 = c0_v;
        req_count1 = c1_v;
        model_edge(cyc + 1);
        prev_rst = rst_v;
    endtask

    // Monitor: consume an expected event whenever the DUT pulses tick or grant.
    ev_t mon_e;
    initial begin
        forever begin
            @(negedge basys_clk);
            if (!done) begin
                if (tick === 1'b1) begin
                    if (tick_exp.size() == 0) begin
                        fail("tick_unexpected");
                    end else begin
                        mon_e = tick_exp.pop_front();
                        check("tick_cycle", 32'(cyc), 32'(mon_e.cyc));
                        check("tick_out_clk", 32'(out_clk), 32'(mon_e.lvl));
                        check("tick_active_count", active_count, mon_e.act);
                        check("tick_busy", 32'(busy), 32'(mon_e.bsy));
                    end
                end
                if (grant !== 2'b00) begin
                    if (grant_exp.size() == 0) begin
                        fail("grant_unexpected");
                    end else begin
                        mon_e = grant_exp.pop_front();
                        check("grant_cycle", 32'(cyc), 32'(mon_e.cyc));
                        check("grant_value", 32'(grant), 32'(mon_e.gnt));
                        check("grant_busy", 32'(busy), 32'(mon_e.bsy));
                        check("grant_active_count", active_count, mon_e.act);
                    end
                end
            end
        end
    end

    initial begin
        bit found;
        // Reset and default 4-cycle half-periods
        rst_v = 1'b1; repeat (3) step();
        rst_v = 1'b0; repeat (12) step();
        // Single request mid half-period
        step();
        c0_v = 32'd1; req_v = 2'b01; repeat (20) step();
        // Both requesting from reset: 0 then 1
        rst_v = 1'b1; req_v = 2'b11; c0_v = 32'd5; c1_v = 32'd2; repeat (2) step();
        rst_v = 1'b0; repeat (40) step();
        // Request landing on a boundary edge
        c0_v = 32'd4; found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!m_wait && m_elapsed == m_active) begin
                found = 1'b1;
                break;
            end
            step();
        end
        if (!found) fail("boundary_search_timeout");
        req_v[0] = 1'b1; repeat (25) step();
        // Same count as active still granted, then count 0
        c1_v = 32'(m_active); req_v[1] = 1'b1; repeat (15) step();
        c0_v = 32'd0; req_v[0] = 1'b1; repeat (20) step();
        // Reset while an update of 7 is waiting
        c0_v = 32'd6; req_v[0] = 1'b1; repeat (30) step();
        c0_v = 32'd7; req_v[0] = 1'b1; found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (m_wait) begin
                found = 1'b1;
                break;
            end
            step();
        end
        if (!found) fail("pending_search_timeout");
        rst_v = 1'b1; step();
        rst_v = 1'b0; repeat (20) step();
        // Randomised traffic with withdrawals and occasional resets
        for (int n = 0; n < 1500; n++) begin
            for (int r = 0; r < 2; r++) begin
                if (req_v[r] == 1'b0) begin
                    if ($urandom_range(0, 7) == 0) begin
                        req_v[r] = 1'b1;
                        if (r == 0) c0_v = 32'($urandom_range(0, 5));
                        else        c1_v = 32'($urandom_range(0, 5));
                    end
                end else if ($urandom_range(0, 39) == 0) begin
                    req_v[r] = 1'b0;
                end
            end
            rst_v = ($urandom_range(0, 299) == 0);
            step();
        end
        rst_v = 1'b0; req_v = 2'b00; repeat (4) step();
        @(negedge basys_clk);
        #1 done = 1'b1;
        check("tick_queue_drained", 32'(tick_exp.size()), 32'd0);
        check("grant_queue_drained", 32'(grant_exp.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
